// File: rtl/fir_decim_packer.sv
// Boxcar decimator with round/shift/saturate, chirp-frame packer and output FIFO.
// Optional FIR_DECIM_SAT_CNT_EN adds a per-frame clipped-sample counter port (sat_cnt).
module fir_decim_packer #(
  parameter int unsigned IN_WIDTH   = 28,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned DEC_LOG2   = 2,
  parameter int unsigned SHIFT      = 12,
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 fir_valid,
  input  logic [IN_WIDTH-1:0]  fir_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 overflow
`ifdef FIR_DECIM_SAT_CNT_EN
  ,
  output logic [15:0]          sat_cnt
`endif
);

  localparam int unsigned ACC_W = IN_WIDTH + DEC_LOG2;
  localparam int unsigned RND_W = ACC_W + 1;
  localparam int unsigned SH    = DEC_LOG2 + SHIFT;
  localparam int unsigned RES_W = RND_W - SH;
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned ENT_W = OUT_WIDTH + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [DEC_LOG2-1:0]  PHASE_LAST = '1;
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic [RND_W-1:0]     RND_BIAS   = RND_W'(1) << (SH - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OCC_W-1:0]     OCC_FULL   = OCC_W'(FIFO_DEPTH);

  logic [0:0]          r_state, w_state_nxt;
  logic [ACC_W-1:0]    r_acc, w_acc_nxt;
  logic [DEC_LOG2-1:0] r_phase, w_phase_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_dump, w_dump_last;

  logic [ACC_W-1:0]     w_sum;
  logic [RND_W-1:0]     w_ext;
  logic [RES_W-1:0]     w_res;
  logic                 w_clip;
  logic [OUT_WIDTH-1:0] w_sat;

  logic                 r_push_vld;
  logic [OUT_WIDTH-1:0] r_push_data;
  logic                 r_push_last;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0] r_occ, w_occ_nxt;
  logic             r_out_valid;
  logic             r_overflow;
  logic             w_pop, w_push_ok;
  logic [ENT_W-1:0] w_head;

  // Round half up at the averaging+shift boundary, then clamp to the output range
  assign w_sum  = r_acc + {{DEC_LOG2{fir_data[IN_WIDTH-1]}}, fir_data};
  assign w_ext  = {w_sum[ACC_W-1], w_sum};
  assign w_res  = RES_W'(($signed(w_ext) + $signed(RND_BIAS)) >>> SH);
  assign w_clip = ~((&w_res[RES_W-1:OUT_WIDTH-1]) | ~(|w_res[RES_W-1:OUT_WIDTH-1]));
  assign w_sat  = w_clip ? (w_res[RES_W-1] ? SAT_MIN : SAT_MAX) : w_res[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_phase <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // frame_start always restarts the frame and masks that cycle's sample, including a final dump
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_dump      = 1'b0;
    w_dump_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_nxt = S_RUN;
          w_acc_nxt   = '0;
          w_phase_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (frame_start) begin
          w_acc_nxt   = '0;
          w_phase_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (fir_valid) begin
          if (r_phase == PHASE_LAST) begin
            w_dump      = 1'b1;
            w_dump_last = (r_cnt == CNT_LAST);
            w_acc_nxt   = '0;
            w_phase_nxt = '0;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_acc_nxt   = w_sum;
            w_phase_nxt = r_phase + DEC_LOG2'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_vld  <= 1'b0;
      r_push_data <= '0;
      r_push_last <= 1'b0;
    end else begin
      r_push_vld <= w_dump;
      if (w_dump) begin
        r_push_data <= w_sat;
        r_push_last <= w_dump_last;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands
  assign w_pop     = r_out_valid & out_ready;
  assign w_push_ok = r_push_vld & ((r_occ != OCC_FULL) | w_pop);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push_ok, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {r_push_last, r_push_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_occ       <= w_occ_nxt;
      r_out_valid <= (w_occ_nxt != '0);
      if (r_push_vld && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = r_out_valid;
  assign out_data  = w_head[OUT_WIDTH-1:0];
  assign out_last  = w_head[OUT_WIDTH];
  assign overflow  = r_overflow;

`ifdef FIR_DECIM_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      r_sat_cnt <= '0;
    end else if (w_dump && w_clip && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
